// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction fetcher with a 2-entry skid FIFO toward decode.
// One outstanding memory request at a time; redirects flush the FIFO and drop in-flight data.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        fetch_enable,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
   state_t      state, state_next;
   logic [31:0] fetch_pc, fetch_pc_next, tail_instr, tail_pc;
   logic [1:0]  count, count_next;
   logic        push, pop, free, issue;

   assign instr_valid = count != 2'd0;

   always_comb begin
      push          = state == WAIT && imem_ack && !redirect;
      pop           = instr_valid && instr_ready;
      count_next    = redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      fetch_pc_next = redirect ? (redirect_pc & ~32'd3) : push ? fetch_pc + 32'd4 : fetch_pc;
      // a new request may only be issued once nothing is outstanding
      free          = state == IDLE || imem_ack;
      issue         = fetch_enable && count_next < 2'd2;
      state_next    = free ? (issue ? WAIT : IDLE) : (state == WAIT && redirect) ? DROP : state;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= IDLE;
         imem_req   <= 1'b0;
         imem_addr  <= RESET_PC;
         fetch_pc   <= RESET_PC;
         count      <= 2'd0;
         instr      <= 32'd0;
         instr_pc   <= 32'd0;
         tail_instr <= 32'd0;
         tail_pc    <= 32'd0;
      end else begin
         state    <= state_next;
         imem_req <= state_next != IDLE;
         fetch_pc <= fetch_pc_next;
         count    <= count_next;
         if (free)
            imem_addr <= fetch_pc_next;
         // on redirect the head keeps its last contents while invalid
         if (!redirect) begin
            if (pop && count == 2'd2) begin
               instr    <= tail_instr;
               instr_pc <= tail_pc;
            end else if (push && (count == 2'd0 || pop)) begin
               instr    <= imem_rdata;
               instr_pc <= imem_addr;
            end
            if (push && (count == 2'd2 || (count == 2'd1 && !pop))) begin
               tail_instr <= imem_rdata;
               tail_pc    <= imem_addr;
            end
         end
      end
   end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front end of the single-issue MIPS datapath: owns the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and delivers them with their PC to the decode stage over valid/ready. The opcode field (instr[31:26]) feeds the control decoder. A 2-entry skid FIFO decouples memory latency from decode stalls. Taken branches and jumps redirect fetch, flushing buffered and in-flight words.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  rising-edge clock
- arst_n  in  1  asynchronous, active-low reset
- fetch_enable  in  1  permits new memory requests
- imem_req  out  1  request valid, registered
- imem_addr  out  32  word-aligned fetch address, registered, stable while imem_req=1
- imem_ack  in  1  request accepted; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  one-cycle pulse, taken branch or jump
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0
- instr_valid  out  1  FIFO head valid
- instr  out  32  FIFO head instruction
- instr_pc  out  32  FIFO head PC
- instr_ready  in  1  decode accepts head when instr_valid=1

## Operation
- fetch_pc register: the next address to request. It advances by 4 on every kept ack and wraps modulo 2^32.
- FIFO: 2 entries of {instr, pc}, with count 0..2.
  - Push on a kept ack.
  - Pop when instr_valid and instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- At most one request is outstanding at any time.
- Issue rule, evaluated every cycle for the next cycle: fetch_enable=1, count_next<2, and not in DROP. A request issued this way always has a free slot when its ack arrives.
- FSM states:
  - IDLE: imem_req=0. Moves to WAIT when the issue rule holds; imem_addr is loaded with fetch_pc.
  - WAIT: imem_req=1.
    - On ack with no redirect: push, fetch_pc+=4. Stay in WAIT with imem_addr=fetch_pc+4 if the issue rule holds, else go to IDLE.
    - redirect with no ack: go to DROP. imem_req and imem_addr stay held, because a request is never withdrawn.
    - redirect with a same-cycle ack: discard the data, then go to IDLE or WAIT at the redirect target.
  - DROP: imem_req=1 with the old address.
    - On ack: discard the data, then go to IDLE or WAIT at fetch_pc.
    - A further redirect while in DROP only updates fetch_pc.
- redirect, in any state:
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - FIFO flushed (count<=0), including any entry popped or pushed in the same cycle.
  - Redirect has priority over every other event.
- fetch_enable=0 blocks only new issues. An outstanding request still completes and its data is pushed.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, state IDLE, count=0, instr_valid=0, instr=0, instr_pc=0.
- Leaving reset with fetch_enable=1: imem_req rises on the first clock edge after arst_n deasserts.
- Latency: an ack in cycle N gives instr_valid=1 in cycle N+1 (registered FIFO).
- Throughput: with a zero-wait memory (ack in the same cycle as req) and instr_ready=1, one instruction per cycle, and imem_req stays high continuously.
- When instr_valid=0, instr and instr_pc hold their last values.
- After a redirect at edge N, instr_valid=0 in cycle N+1.
  - The first instruction from the target arrives no earlier than N+2, or later if a DROP is pending.
- Reset asserted mid-transaction returns everything to reset values immediately. Any pending ack is ignored.

## Test plan
- Reset, fetch_enable=1, zero-wait memory returning addr as data, instr_ready=1 → instr_pc sequence 0,4,8,… on consecutive cycles; first instr_valid two edges after reset release.
- instr_ready=0 held → exactly 2 words buffered (pc 0,4), imem_req drops, imem_addr holds 8. Release instr_ready → pc 0,4,8 delivered in order with no duplicates.
- Memory ack delayed 3 cycles with redirect to 0x100 in the second wait cycle → req and addr stay held until ack, that data is never delivered, next request addr=0x100, first delivered instr_pc=0x100.
- Redirect to 0x203 in the same cycle as an ack, with FIFO holding 1 entry → FIFO empties, the acked word is dropped, next imem_addr=0x200.
- RESET_PC=32'hFFFF_FFF8 → delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- fetch_enable deasserted while a request is outstanding → that word is still delivered; no further imem_req until fetch_enable=1.
